// File: rtl/seq_arithmetic_unit.sv
// Registered N-bit arithmetic unit (add, subtract, iterative arithmetic shift right,
// optional iterative shift-add multiply) with a start/busy/done handshake. Define MUL_EN to build the multiplier.
module seq_arithmetic_unit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   select,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out,
    output logic [N-1:0] out_hi,
    output logic         cout,
    output logic         zero,
    output logic         negative,
    output logic         overflow
);

    localparam int SW = $clog2(N);
    localparam int CW = $clog2(N + 1);
`ifdef MUL_EN
    localparam int AW = 2 * N;
`else
    localparam int AW = N;
`endif

    typedef enum logic [1:0] {
        IDLE,
        EXEC_SHIFT,
        EXEC_MUL
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [AW-1:0]  acc;
    logic [CW-1:0]  cnt;
    logic [N:0]     sum_ext;
    logic [N:0]     diff_ext;
    logic [SW-1:0]  shamt;
    logic [N-1:0]   shift_step;
    logic           accept;
    logic           wr_en;
    logic [N-1:0]   res_out;
    logic [N-1:0]   res_hi;
    logic           res_cout;
    logic           res_ovf;

`ifdef MUL_EN
    logic [N-1:0]   mcand;
    logic [N:0]     mul_sum;
    logic [AW-1:0]  mul_next;

    // Product register holds {partial high half, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[AW-1:N]} + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, acc[N-1:1]};
`endif

    assign shamt      = b[SW-1:0];
    assign busy       = (state != IDLE);
    assign accept     = start && (state == IDLE);
    assign sum_ext    = {1'b0, a} + {1'b0, b};
    assign diff_ext   = {1'b0, a} - {1'b0, b};
    assign shift_step = {acc[N-1], acc[N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        res_out    = '0;
        res_hi     = '0;
        res_cout   = 1'b0;
        res_ovf    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (select)
                        2'b00: begin
                            wr_en    = 1'b1;
                            res_out  = sum_ext[N-1:0];
                            res_cout = sum_ext[N];
                            res_ovf  = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
                        end
                        2'b01: begin
                            wr_en    = 1'b1;
                            res_out  = diff_ext[N-1:0];
                            res_cout = ~diff_ext[N];
                            res_ovf  = (a[N-1] != b[N-1]) && (diff_ext[N-1] != a[N-1]);
                        end
                        2'b10: begin
                            if (shamt == '0) begin
                                wr_en   = 1'b1;
                                res_out = a;
                            end else begin
                                state_next = EXEC_SHIFT;
                            end
                        end
                        default: begin
`ifdef MUL_EN
                            state_next = EXEC_MUL;
`else
                            wr_en = 1'b1;
`endif
                        end
                    endcase
                end
            end
            EXEC_SHIFT: begin
                if (cnt == CW'(1)) begin
                    wr_en      = 1'b1;
                    res_out    = shift_step;
                    state_next = IDLE;
                end
            end
            EXEC_MUL: begin
`ifdef MUL_EN
                if (cnt == CW'(1)) begin
                    wr_en      = 1'b1;
                    res_out    = mul_next[N-1:0];
                    res_hi     = mul_next[AW-1:N];
                    res_ovf    = (mul_next[AW-1:N] != '0);
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Working register and iteration counter; operands are captured only on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
`ifdef MUL_EN
            mcand <= '0;
`endif
        end else if (accept) begin
            if (select == 2'b10) begin
                acc <= AW'(a);
                cnt <= CW'(shamt);
            end
`ifdef MUL_EN
            else if (select == 2'b11) begin
                acc   <= AW'(b);
                mcand <= a;
                cnt   <= CW'(N);
            end
`endif
        end else if (state == EXEC_SHIFT) begin
            acc[N-1:0] <= shift_step;
            cnt        <= cnt - CW'(1);
        end
`ifdef MUL_EN
        else if (state == EXEC_MUL) begin
            acc <= mul_next;
            cnt <= cnt - CW'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            out      <= '0;
            out_hi   <= '0;
            cout     <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= wr_en;
            if (wr_en) begin
                out      <= res_out;
                out_hi   <= res_hi;
                cout     <= res_cout;
                zero     <= (res_out == '0);
                negative <= res_out[N-1];
                overflow <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_seq_arithmetic_unit.sv
// Self-checking bench for seq_arithmetic_unit (N=4); expectations follow MUL_EN when it is defined.
module tb_seq_arithmetic_unit;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   select;
    logic         busy;
    logic         done;
    logic [N-1:0] out;
    logic [N-1:0] out_hi;
    logic         cout;
    logic         zero;
    logic         negative;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] out;
        logic [3:0] hi;
        logic       cout;
        logic       zero;
        logic       neg;
        logic       ovf;
    } res_t;

    res_t exp_q[$];

    seq_arithmetic_unit #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .select   (select),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .out_hi   (out_hi),
        .cout     (cout),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic res_t observed();
        res_t r;
        r.out  = out;
        r.hi   = out_hi;
        r.cout = cout;
        r.zero = zero;
        r.neg  = negative;
        r.ovf  = overflow;
        return r;
    endfunction

    // Reference arithmetic done with plain integers and signed ranges
    function automatic res_t model(input logic [1:0] sel, input logic [3:0] va, input logic [3:0] vb);
        res_t r;
        int sa, sb, full, sres, p, s;
        r    = '0;
        sa   = va[3] ? int'(va) - 16 : int'(va);
        sb   = vb[3] ? int'(vb) - 16 : int'(vb);
        case (sel)
            2'b00: begin
                full   = int'(va) + int'(vb);
                r.out  = full[3:0];
                r.cout = (full > 15);
                sres   = sa + sb;
                r.ovf  = (sres > 7) || (sres < -8);
            end
            2'b01: begin
                full   = int'(va) - int'(vb);
                r.out  = full[3:0];
                r.cout = (va >= vb);
                sres   = sa - sb;
                r.ovf  = (sres > 7) || (sres < -8);
            end
            2'b10: begin
                s     = int'(vb[1:0]);
                p     = sa >>> s;
                r.out = p[3:0];
            end
            default: begin
`ifdef MUL_EN
                p     = int'(va) * int'(vb);
                r.out = p[3:0];
                r.hi  = p[7:4];
                r.ovf = (p > 15);
`endif
            end
        endcase
        r.zero = (r.out == 4'h0);
        r.neg  = r.out[3];
        return r;
    endfunction

    function automatic int exp_latency(input logic [1:0] sel, input logic [3:0] vb);
        if (sel == 2'b10) return int'(vb[1:0]);
`ifdef MUL_EN
        if (sel == 2'b11) return N;
`endif
        return 0;
    endfunction

    task automatic run_op(input logic [1:0] sel, input logic [3:0] va, input logic [3:0] vb,
                          output int lat, output logic busy_k);
        @(negedge clk);
        select = sel;
        a      = va;
        b      = vb;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        busy_k = busy;
        lat    = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        res_t o;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        select = '0;
        #12;
        o = observed();
        checks++;
        if (o !== res_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h expected %h", o, res_t'(0));
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake got busy=%b done=%b expected 0 0", busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        res_t e, o;
        int lat;
        logic bk;
        exp_q.push_back('{out: 4'h1, hi: 4'h0, cout: 1'b1, zero: 1'b0, neg: 1'b0, ovf: 1'b1});
        run_op(2'b00, 4'd9, 4'd8, lat, bk);
        o = observed();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("[TB] FAIL add_result got %h expected %h", o, e);
        end
        checks++;
        if (lat != 0 || bk !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_timing got lat=%0d busy=%b expected 0 0", lat, bk);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_done_width got done=%b expected 0", done);
        end
    endtask

    task automatic test_sub();
        res_t e, o;
        int lat;
        logic bk;
        exp_q.push_back('{out: 4'hE, hi: 4'h0, cout: 1'b0, zero: 1'b0, neg: 1'b1, ovf: 1'b0});
        run_op(2'b01, 4'd3, 4'd5, lat, bk);
        o = observed();
        e = exp_q.pop_front();
        checks++;
        if (o !== e || lat != 0) begin
            errors++;
            $display("[TB] FAIL sub_3_5 got %h lat=%0d expected %h lat=0", o, lat, e);
        end
        exp_q.push_back('{out: 4'h0, hi: 4'h0, cout: 1'b1, zero: 1'b1, neg: 1'b0, ovf: 1'b0});
        run_op(2'b01, 4'd5, 4'd5, lat, bk);
        o = observed();
        e = exp_q.pop_front();
        checks++;
        if (o !== e || lat != 0) begin
            errors++;
            $display("[TB] FAIL sub_5_5 got %h lat=%0d expected %h lat=0", o, lat, e);
        end
    endtask

    task automatic test_shift();
        res_t e, o;
        int lat;
        logic bk;
        exp_q.push_back('{out: 4'hE, hi: 4'h0, cout: 1'b0, zero: 1'b0, neg: 1'b1, ovf: 1'b0});
        run_op(2'b10, 4'b1000, 4'd2, lat, bk);
        o = observed();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("[TB] FAIL shift2_result got %h expected %h", o, e);
        end
        checks++;
        if (lat != 2 || bk !== 1'b1) begin
            errors++;
            $display("[TB] FAIL shift2_timing got lat=%0d busy=%b expected 2 1", lat, bk);
        end
        exp_q.push_back('{out: 4'h8, hi: 4'h0, cout: 1'b0, zero: 1'b0, neg: 1'b1, ovf: 1'b0});
        run_op(2'b10, 4'b1000, 4'd0, lat, bk);
        o = observed();
        e = exp_q.pop_front();
        checks++;
        if (o !== e || lat != 0 || bk !== 1'b0) begin
            errors++;
            $display("[TB] FAIL shift0 got %h lat=%0d busy=%b expected %h 0 0", o, lat, bk, e);
        end
    endtask

    task automatic test_mul();
        res_t e, o;
        int lat, exp_lat;
        logic bk;
`ifdef MUL_EN
        exp_q.push_back('{out: 4'hA, hi: 4'h2, cout: 1'b0, zero: 1'b0, neg: 1'b1, ovf: 1'b1});
        exp_lat = 4;
`else
        exp_q.push_back('{out: 4'h0, hi: 4'h0, cout: 1'b0, zero: 1'b1, neg: 1'b0, ovf: 1'b0});
        exp_lat = 0;
`endif
        run_op(2'b11, 4'd7, 4'd6, lat, bk);
        o = observed();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("[TB] FAIL mul_result got %h expected %h", o, e);
        end
        checks++;
        if (lat != exp_lat || bk !== (exp_lat != 0)) begin
            errors++;
            $display("[TB] FAIL mul_timing got lat=%0d busy=%b expected %0d %b", lat, bk, exp_lat, exp_lat != 0);
        end
    endtask

    task automatic test_busy_ignore(input logic [1:0] sel, input logic [3:0] va, input logic [3:0] vb);
        res_t e, o;
        int lat, extra;
        exp_q.push_back(model(sel, va, vb));
        @(negedge clk);
        select = sel;
        a      = va;
        b      = vb;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        select = 2'b00;
        a      = 4'd1;
        b      = 4'd1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        o = observed();
        e = exp_q.pop_front();
        checks++;
        if (o !== e || lat != exp_latency(sel, vb)) begin
            errors++;
            $display("[TB] FAIL busy_ignore_result got %h lat=%0d expected %h lat=%0d", o, lat, e, exp_latency(sel, vb));
        end
        extra = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        o = observed();
        checks++;
        if (extra != 0 || o !== e) begin
            errors++;
            $display("[TB] FAIL busy_ignore_hold got extra_done=%0d out=%h expected 0 %h", extra, o, e);
        end
    endtask

    task automatic test_reset_mid();
        res_t e, o;
        int lat, extra;
        logic bk;
        run_op(2'b00, 4'd9, 4'd8, lat, bk);
        @(negedge clk);
`ifdef MUL_EN
        select = 2'b11;
        a      = 4'd7;
        b      = 4'd6;
`else
        select = 2'b10;
        a      = 4'b1000;
        b      = 4'd3;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        o = observed();
        checks++;
        if (o !== res_t'(0) || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid got %h busy=%b done=%b expected %h 0 0", o, busy, done, res_t'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(model(2'b00, 4'd2, 4'd3));
        run_op(2'b00, 4'd2, 4'd3, lat, bk);
        o = observed();
        e = exp_q.pop_front();
        checks++;
        if (o !== e || lat != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_add got %h lat=%0d expected %h lat=0", o, lat, e);
        end
        extra = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_discard got extra_done=%0d expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        res_t e, o;
        logic [1:0] sel;
        logic [3:0] va, vb;
        for (int i = 0; i < 16; i++) begin
            sel = 2'($urandom_range(0, 2));
            va  = 4'($urandom_range(0, 15));
            vb  = 4'($urandom_range(0, 15));
            if (sel == 2'b10) vb[1:0] = 2'b00;
            @(negedge clk);
            select = sel;
            a      = va;
            b      = vb;
            start  = 1'b1;
            exp_q.push_back(model(sel, va, vb));
            @(posedge clk);
            #1;
            o = observed();
            e = exp_q.pop_front();
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || o !== e) begin
                errors++;
                $display("[TB] FAIL b2b_%0d sel=%0d a=%h b=%h got done=%b busy=%b %h expected 1 0 %h",
                         i, sel, va, vb, done, busy, o, e);
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_random();
        res_t e, o;
        logic [1:0] sel;
        logic [3:0] va, vb;
        int lat;
        logic bk;
        for (int i = 0; i < 24; i++) begin
            sel = 2'($urandom_range(0, 3));
            va  = 4'($urandom_range(0, 15));
            vb  = 4'($urandom_range(0, 15));
            exp_q.push_back(model(sel, va, vb));
            run_op(sel, va, vb, lat, bk);
            o = observed();
            e = exp_q.pop_front();
            checks++;
            if (o !== e || lat != exp_latency(sel, vb)) begin
                errors++;
                $display("[TB] FAIL rand_%0d sel=%0d a=%h b=%h got %h lat=%0d expected %h lat=%0d",
                         i, sel, va, vb, o, lat, e, exp_latency(sel, vb));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_mul();
        test_busy_ignore(2'b10, 4'b1000, 4'd3);
`ifdef MUL_EN
        test_busy_ignore(2'b11, 4'd7, 4'd6);
`endif
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_arithmetic_unit.md
# seq_arithmetic_unit

Registered, parametrised N-bit arithmetic unit with a start/busy/done handshake. It supports single-cycle add and subtract, an iterative arithmetic right shift (one bit per cycle), and an optional iterative unsigned shift-add multiply. All results and status flags are registered, so the block can sit directly on a datapath bus without a combinational path from operands to outputs.

## Interface
- N, default 4: operand/result width, N ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- a  input  N  operand A.
- b  input  N  operand B; for shifts, the amount is b[$clog2(N)-1:0].
- select  input  2  op code: 00 add, 01 subtract, 10 arithmetic shift right, 11 multiply.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when a result is written.
- out  output  N  result, low N bits.
- out_hi  output  N  high half of the product; 0 for all other ops.
- cout  output  1  add: carry out; sub: 1 when a ≥ b (unsigned, no borrow); else 0.
- zero  output  1  out == 0.
- negative  output  1  out[N-1].
- overflow  output  1  add/sub: signed overflow; mul: out_hi ≠ 0; shift: 0.

## Operation
- FSM states:
  - IDLE to EXEC_SHIFT when select=10 and s>0.
  - IDLE to EXEC_MUL when select=11 and MUL is enabled.
  - EXEC_* to IDLE on completion.
  - All other accepted ops complete without leaving IDLE.
- Accept: at a rising edge with start=1 and busy=0, latch a, b and select. Operands are not re-sampled until the next accept.
- Add: out = (a+b)[N-1:0], cout = carry.
- Subtract: out = (a−b)[N-1:0] in two's complement.
- Shift: s = b[$clog2(N)-1:0], with s ≤ N−1.
  - Each cycle shifts the working register right by 1 and replicates the sign bit.
  - s=0 gives out=a.
- Multiply: unsigned radix-2 shift-add over N iterations; {out_hi, out} = a*b.
- Outputs and flags hold their last value until the next completion. Intermediate values never appear on out.
- start while busy=1 is ignored and not queued.
- Reset (any time, including mid-operation):
  - FSM returns to IDLE.
  - busy, done, out, out_hi, cout, zero, negative, overflow all become 0.
  - The in-flight operation is discarded.

## Timing
- Label the accept edge as edge k.
- Add, subtract, shift with s=0, and multiply when disabled:
  - Result, flags and done=1 are written at edge k.
  - busy stays 0.
  - Back-to-back accepts are allowed every cycle.
- Shift with s>0:
  - busy=1 from edge k to edge k+s.
  - Result and done=1 at edge k+s; busy=0 at that edge.
- Multiply: busy=1 from edge k; result and done at edge k+N.
- done is high for exactly one cycle per completion.
- A new start may be accepted at the edge following the one that clears busy.

## Configuration
- MUL_EN:
  - When defined, select=11 runs the N-cycle multiply described above.
  - When undefined, the multiply datapath is not built. select=11 completes like a single-cycle op with out=0, out_hi=0, cout=0, overflow=0, zero=1.

## Test plan
- N=4, add a=9, b=8 → at edge k: out=1, cout=1, overflow=1, zero=0, done pulse, busy stays 0.
- Subtract a=3, b=5 → out=4'hE, cout=0, negative=1, overflow=0. Then a=5, b=5 → out=0, zero=1, cout=1.
- Shift a=4'b1000, b=2 → busy high 2 cycles; at edge k+2: out=4'b1110, negative=1, done pulse. With b=0 → out=a in a single cycle.
- With MUL_EN defined, multiply a=7, b=6 → busy for 4 cycles; at edge k+4: out=4'hA, out_hi=4'h2, overflow=1. With MUL_EN undefined, the same stimulus gives out=0, zero=1 at edge k.
- During a multiply, pulse start with new operands → ignored, and the original result is unchanged.
- Assert rst at cycle 2 of a multiply → all outputs 0 immediately (asynchronous). After release, the next add completes normally.
